snow64_int_to_bfloat16_pipe: RTL and testbench



---
 rtl/snow64_int_to_bfloat16_pkg.sv | 40 ++++
 rtl/snow64_count_leading_zeros64.sv | 21 ++
 rtl/snow64_int_to_bfloat16_pipe_round_pack.sv | 38 +++
 rtl/snow64_int_to_bfloat16_pipe.sv | 155 +++++++++++++++
 tb/tb_snow64_int_to_bfloat16_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snow64_int_to_bfloat16_pkg.sv
// Shared types and constants for the Snow64 integer-to-bfloat16 pipeline.
// Optional feature macro: SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN adds the inexact flag
// to the S3 result record.
package snow64_int_to_bfloat16_pkg;

    localparam int unsigned BFLOAT16_EXP_BIAS   = 127;
    localparam int unsigned BFLOAT16_MANT_WIDTH = 7;
    // Exponent of a value whose leading one sits at bit 63 of the normalized word.
    localparam int unsigned INT64_NORM_EXP      = BFLOAT16_EXP_BIAS + 63;

    typedef enum logic [1:0] {
        INT_WIDTH_8  = 2'd0,
        INT_WIDTH_16 = 2'd1,
        INT_WIDTH_32 = 2'd2,
        INT_WIDTH_64 = 2'd3
    } int_width_e;

    // S1: sign and unsigned magnitude of the extended operand.
    typedef struct packed {
        logic        sign;
        logic [63:0] mag;
    } s1_reg_t;

    // S2: normalized magnitude; the leading one (bit 63) is implicit and not stored.
    typedef struct packed {
        logic        sign;
        logic        is_zero;
        logic [6:0]  lz;
        logic [62:0] norm_frac;
    } s2_reg_t;

    // S3: packed bfloat16 result.
    typedef struct packed {
        logic [15:0] data;
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
        logic        inexact;
`endif
    } s3_reg_t;

endpackage

// File: rtl/snow64_count_leading_zeros64.sv
// 64-bit leading-zero counter used as the normalization stage; result range 0..64.
module Snow64CountLeadingZeros64 (
    input  logic [63:0] in_to_count,
    output logic [6:0]  out_num_leading_zeros
);

    logic w_found;

    // Priority scan from the MSB; an all-zero word reports 64.
    always_comb begin
        out_num_leading_zeros = 7'd64;
        w_found               = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!w_found && in_to_count[i]) begin
                out_num_leading_zeros = 7'(63 - i);
                w_found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snow64_int_to_bfloat16_pipe_round_pack.sv
// Combinational round-to-nearest-even and bfloat16 pack for a normalized magnitude.
// Optional feature macro: SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN drives o_result.inexact.
module snow64_bfloat16_round_pack
    import snow64_int_to_bfloat16_pkg::*;
(
    input  logic        i_sign,
    input  logic        i_is_zero,
    input  logic [6:0]  i_lz,
    input  logic [62:0] i_norm_frac,
    output s3_reg_t     o_result
);

    logic [BFLOAT16_MANT_WIDTH-1:0] w_mant;
    logic                           w_guard;
    logic                           w_sticky;
    logic                           w_round_up;
    logic [BFLOAT16_MANT_WIDTH:0]   w_mant_rnd;
    logic [7:0]                     w_exp;

    // RNE: a carry out of the mantissa bumps the exponent and leaves the mantissa zero.
    always_comb begin
        w_mant     = i_norm_frac[62:56];
        w_guard    = i_norm_frac[55];
        w_sticky   = |i_norm_frac[54:0];
        w_round_up = w_guard && (w_sticky || w_mant[0]);
        w_mant_rnd = {1'b0, w_mant} + {{BFLOAT16_MANT_WIDTH{1'b0}}, w_round_up};
        w_exp      = 8'(INT64_NORM_EXP) - {1'b0, i_lz}
                   + {7'd0, w_mant_rnd[BFLOAT16_MANT_WIDTH]};
        o_result   = '0;
        if (!i_is_zero) begin
            o_result.data = {i_sign, w_exp, w_mant_rnd[BFLOAT16_MANT_WIDTH-1:0]};
        end
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
        o_result.inexact = w_guard || w_sticky;
`endif
    end

endmodule

// File: rtl/snow64_int_to_bfloat16_pipe.sv
// Three-stage integer-to-bfloat16 converter with valid/ready flow control.
// S1 extends and takes the magnitude, S2 normalizes via the CLZ, S3 rounds and packs.
// Optional feature macro: SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN adds out_inexact.
module snow64_int_to_bfloat16_pipe
    import snow64_int_to_bfloat16_pkg::*;
#(
    parameter int unsigned MSB_POS_IN = 63,
    parameter int unsigned STAGES     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MSB_POS_IN:0]   in_data,
    input  logic [1:0]            in_int_width,
    input  logic                  in_is_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
    ,
    output logic                  out_inexact
`endif
);

    // The latency is structural; refuse any other value at elaboration.
    if (STAGES != 3) begin : g_stages_check
        $error("snow64_int_to_bfloat16_pipe: STAGES must be 3");
    end

    s1_reg_t    r_s1;
    s2_reg_t    r_s2;
    s3_reg_t    r_s3;
    logic       r_s1_valid;
    logic       r_s2_valid;
    logic       r_s3_valid;

    logic       w_s1_free;
    logic       w_s2_free;
    logic       w_s3_free;
    int_width_e w_width;
    logic       w_sign;
    logic [63:0] w_ext;
    logic [63:0] w_mag;
    logic [6:0]  w_lz;
    logic [63:0] w_norm;
    s3_reg_t     w_packed;

    // Ready chain: a stage may load when empty or when its content moves on this edge.
    always_comb begin
        w_s3_free = !r_s3_valid || out_ready;
        w_s2_free = !r_s2_valid || w_s3_free;
        w_s1_free = !r_s1_valid || w_s2_free;
        in_ready  = w_s1_free;
        out_valid = r_s3_valid;
        out_data  = r_s3.data;
    end

`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
    assign out_inexact = r_s3.inexact;
`endif

    // S1: sign/zero-extend the selected width and take the unsigned magnitude.
    always_comb begin
        w_width = int_width_e'(in_int_width);
        w_sign  = 1'b0;
        w_ext   = '0;
        case (w_width)
            INT_WIDTH_8: begin
                w_sign = in_is_signed && in_data[7];
                w_ext  = {{56{w_sign}}, in_data[7:0]};
            end
            INT_WIDTH_16: begin
                w_sign = in_is_signed && in_data[15];
                w_ext  = {{48{w_sign}}, in_data[15:0]};
            end
            INT_WIDTH_32: begin
                w_sign = in_is_signed && in_data[31];
                w_ext  = {{32{w_sign}}, in_data[31:0]};
            end
            INT_WIDTH_64: begin
                w_sign = in_is_signed && in_data[63];
                w_ext  = in_data[63:0];
            end
            default: begin
                w_sign = 1'b0;
                w_ext  = '0;
            end
        endcase
        // Two's-complement negate; -2^63 maps to 2^63, which fits unsigned.
        w_mag = w_sign ? (~w_ext + 64'd1) : w_ext;
    end

    Snow64CountLeadingZeros64 u_clz (
        .in_to_count           (r_s1.mag),
        .out_num_leading_zeros (w_lz)
    );

    // S2: shift the leading one to bit 63; a shift by 64 yields zero.
    always_comb begin
        w_norm = r_s1.mag << w_lz;
    end

    snow64_bfloat16_round_pack u_round_pack (
        .i_sign      (r_s2.sign),
        .i_is_zero   (r_s2.is_zero),
        .i_lz        (r_s2.lz),
        .i_norm_frac (r_s2.norm_frac),
        .o_result    (w_packed)
    );

    // Stage 1 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.sign <= w_sign;
                r_s1.mag  <= w_mag;
            end
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2.sign      <= r_s1.sign;
                r_s2.is_zero   <= (w_lz == 7'd64);
                r_s2.lz        <= w_lz;
                r_s2.norm_frac <= w_norm[62:0];
            end
        end
    end

    // Stage 3 register; holds the result while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_valid <= 1'b0;
            r_s3       <= '0;
        end else if (w_s3_free) begin
            r_s3_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_s3 <= w_packed;
            end
        end
    end

endmodule

// File: tb/tb_snow64_int_to_bfloat16_pipe.sv
// Directed self-checking bench for snow64_int_to_bfloat16_pipe.
// Honors SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN when the design is built with it.
module tb_snow64_int_to_bfloat16_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_int_width;
    logic        in_is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
    logic        out_inexact;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    snow64_int_to_bfloat16_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_int_width (in_int_width),
        .in_is_signed (in_is_signed),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
        ,
        .out_inexact  (out_inexact)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: round the magnitude by right-shift and remainder comparison.
    function automatic logic [16:0] ref_conv(input logic [1:0] w, input logic s,
                                             input logic [63:0] d);
        int          nb;
        int          p;
        logic [63:0] v;
        logic [63:0] q;
        logic [63:0] rem;
        logic [63:0] half;
        logic        neg;
        logic [7:0]  e;
        nb = 8 << w;
        v  = d;
        if (nb < 64) v = d & ((64'd1 << nb) - 64'd1);
        neg = s && v[nb-1];
        if (neg) v = (nb < 64) ? ((64'd1 << nb) - v) : (64'd0 - v);
        if (v == 64'd0) return 17'h0;
        p = 0;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        rem = 64'd0;
        if (p <= 7) begin
            q = v << (7 - p);
        end else begin
            q    = v >> (p - 7);
            rem  = v & ((64'd1 << (p - 7)) - 64'd1);
            half = 64'd1 << (p - 8);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == 64'd256) begin
                q = 64'd128;
                p = p + 1;
            end
        end
        e = 8'(127 + p);
        return {rem != 64'd0, neg, e, q[6:0]};
    endfunction

    // Present one lane with out_ready high and check the fixed latency and result.
    task automatic send_and_check(input string tag, input logic [1:0] w, input logic s,
                                  input logic [63:0] d, input logic [15:0] exp_d,
                                  input logic exp_ix);
        @(negedge clk);
        in_valid     = 1'b1;
        in_int_width = w;
        in_is_signed = s;
        in_data      = d;
        out_ready    = 1'b1;
        #1 check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "/valid_e1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "/valid_e2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "/valid_e3"}, 64'(out_valid), 64'd1);
        check({tag, "/data"}, 64'(out_data), 64'(exp_d));
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
        check({tag, "/inexact"}, 64'(out_inexact), 64'(exp_ix));
`else
        if (exp_ix === 1'bx) $display("note: unknown inexact expectation for %s", tag);
`endif
    endtask

    logic [63:0] bp_vals [5];
    logic [15:0] bp_exp  [5];
    logic [63:0] sb_q [$];
    logic [63:0] exp_v;
    logic [16:0] r;
    int          k;
    int          j;

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        in_int_width = 2'd0;
        in_is_signed = 1'b0;
        out_ready    = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/out_data", 64'(out_data), 64'h0);
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
        check("reset/out_inexact", 64'(out_inexact), 64'd0);
`endif
        rst = 1'b0;

        // Directed conversions
        send_and_check("s8_m1",     2'd0, 1'b1, 64'hFF,                  16'hBF80, 1'b0);
        send_and_check("u64_zero",  2'd3, 1'b0, 64'h0,                   16'h0000, 1'b0);
        send_and_check("s64_min",   2'd3, 1'b1, 64'h8000_0000_0000_0000, 16'hDF00, 1'b0);
        send_and_check("u16_tie_e", 2'd1, 1'b0, 64'h0181,                16'h43C0, 1'b1);
        send_and_check("u16_tie_o", 2'd1, 1'b0, 64'h0183,                16'h43C2, 1'b1);
        send_and_check("u16_ovf",   2'd1, 1'b0, 64'h01FF,                16'h4400, 1'b1);
        send_and_check("s32_min",   2'd2, 1'b1, 64'h8000_0000,           16'hCF00, 1'b0);
        send_and_check("u8_upper",  2'd0, 1'b0, 64'hFFFF_FF05,           16'h40A0, 1'b0);

        // Back-pressure: only three lanes fit while the output is stalled
        bp_vals = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        bp_exp  = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0};
        k = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid     = (k < 5);
            in_int_width = 2'd1;
            in_is_signed = 1'b0;
            in_data      = bp_vals[(k < 5) ? k : 0];
            #1;
            if (in_valid && in_ready) k++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp/accepted", 64'(k), 64'd3);
        #1 check("bp/in_ready_low", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp/stall_valid", 64'(out_valid), 64'd1);
            check("bp/stall_data", 64'(out_data), 64'(bp_exp[0]));
        end
        j = 0;
        for (int c = 0; c < 30 && j < 5; c++) begin
            @(negedge clk);
            out_ready    = 1'b1;
            in_valid     = (k < 5);
            in_data      = bp_vals[(k < 5) ? k : 0];
            #1;
            if (out_valid && out_ready) begin
                check("bp/drain_data", 64'(out_data), 64'(bp_exp[j]));
                j++;
            end
            if (in_valid && in_ready) k++;
        end
        in_valid = 1'b0;
        check("bp/drained", 64'(j), 64'd5);
        @(negedge clk);
        @(negedge clk);
        check("bp/no_dup", 64'(out_valid), 64'd0);

        // Streaming with random operands and random back-pressure
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_int_width = 2'($urandom_range(0, 3));
            in_is_signed = 1'($urandom_range(0, 1));
            in_data      = {$urandom, $urandom} >> $urandom_range(0, 63);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_0000_0000;
                check("stream/data", 64'(out_data), {48'd0, exp_v[15:0]});
`ifdef SNOW64_INT_TO_BFLOAT16_PIPE_INEXACT_EN
                check("stream/inexact", 64'(out_inexact), 64'(exp_v[16]));
`endif
            end
            if (in_valid && in_ready) begin
                r = ref_conv(in_int_width, in_is_signed, in_data);
                sb_q.push_back(64'(r));
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) begin
                exp_v = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_0000_0000;
                check("stream/drain", 64'(out_data), {48'd0, exp_v[15:0]});
            end
        end
        check("stream/empty", 64'(sb_q.size()), 64'd0);

        // Reset with two lanes in flight
        @(negedge clk);
        out_ready    = 1'b0;
        in_valid     = 1'b1;
        in_int_width = 2'd0;
        in_is_signed = 1'b0;
        in_data      = 64'd7;
        @(negedge clk);
        in_data = 64'd9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst/pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rst/out_valid", 64'(out_valid), 64'd0);
        check("rst/in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst/no_stale", 64'(out_valid), 64'd0);
        end
        send_and_check("rst/after", 2'd0, 1'b0, 64'd3, 16'h4040, 1'b0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
